// File: rtl/alu_result_fifo.sv
// alu_result_fifo: captures ALU results under a valid/ready handshake.
// Status flags are derived when an entry is pushed and stored with it.
// Entries are held in a small first-word-fall-through FIFO.
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic              CarryOut,
  input  logic [OP_W-1:0]   Opcode,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [OP_W-1:0]   Out_Opcode,
  output logic              Out_Carry,
  output logic              Out_Zero,
  output logic              Out_Wide,
  output logic [CNT_W-1:0]  Count,
  output logic [7:0]        Stall_Cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One stored entry: result, issuing opcode and the flags derived at push time.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   op;
    logic              carry;
    logic              zero;
    logic              wide;
  } entry_t;

  // Storage is never reset; stale contents are hidden behind Out_Valid.
  // Asynchronous read of this small array gives the fall-through head.
  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [7:0]       stall_cnt_reg, stall_cnt_next;

  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head_entry;

  // Handshake decodes come only from registered occupancy, so a full FIFO
  // refuses input even while it is being popped (no pass-through).
  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = In_Valid && in_ready;
  assign pop       = out_valid && Out_Ready;

  // Flags are computed from the live ALU inputs; they only matter on a push.
  // Carry is meaningful only for the add opcode (all zeros).
  always_comb begin
    push_entry       = '0;
    push_entry.data  = ALU_Out;
    push_entry.op    = Opcode;
    push_entry.carry = CarryOut && (Opcode == '0);
    push_entry.zero  = (ALU_Out == '0);
    push_entry.wide  = |ALU_Out[DATA_W-1:8];
  end

  // Next-state for pointers, occupancy and the stall counter; Flush overrides
  // any push or pop in the same cycle.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    stall_cnt_next = stall_cnt_reg;
    if (Flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      stall_cnt_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      if (In_Valid && !in_ready && (stall_cnt_reg != 8'hFF)) begin
        stall_cnt_next = stall_cnt_reg + 8'd1;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Entry storage write; a push during reset or flush is dropped.
  always_ff @(posedge clk) begin
    if (!rst && !Flush && push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // Head entry, masked to zero whenever the FIFO is empty.
  always_comb begin
    head_entry = '0;
    if (out_valid) begin
      head_entry = mem[rd_ptr_reg];
    end
  end

  assign In_Ready   = in_ready;
  assign Out_Valid  = out_valid;
  assign Out_Data   = head_entry.data;
  assign Out_Opcode = head_entry.op;
  assign Out_Carry  = head_entry.carry;
  assign Out_Zero   = head_entry.zero;
  assign Out_Wide   = head_entry.wide;
  assign Count      = count_reg;
  assign Stall_Cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed testbench for alu_result_fifo (DEPTH=4, DATA_W=16, OP_W=5).
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] ALU_Out;
  logic        CarryOut;
  logic [4:0]  Opcode;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Data;
  logic [4:0]  Out_Opcode;
  logic        Out_Carry;
  logic        Out_Zero;
  logic        Out_Wide;
  logic [2:0]  Count;
  logic [7:0]  Stall_Cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_result_fifo #(.DEPTH(4), .DATA_W(16), .OP_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .Flush      (Flush),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .ALU_Out    (ALU_Out),
    .CarryOut   (CarryOut),
    .Opcode     (Opcode),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Data   (Out_Data),
    .Out_Opcode (Out_Opcode),
    .Out_Carry  (Out_Carry),
    .Out_Zero   (Out_Zero),
    .Out_Wide   (Out_Wide),
    .Count      (Count),
    .Stall_Cnt  (Stall_Cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Flush     = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    ALU_Out   = 16'h0;
    CarryOut  = 1'b0;
    Opcode    = 5'd0;
  endtask

  // Presents one result for exactly one edge.
  task automatic push_one(input logic [15:0] d, input logic c, input logic [4:0] op);
    In_Valid = 1'b1;
    ALU_Out  = d;
    CarryOut = c;
    Opcode   = op;
    tick();
    In_Valid = 1'b0;
    $display("[TB] push data=%h carry=%0d op=%0d count=%0d", d, c, op, Count);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (Count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", Count); end
    tests_run++;
    if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", Out_Valid); end
    tests_run++;
    if (In_Ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", In_Ready); end
    tests_run++;
    if (Out_Data !== 16'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0000", Out_Data); end
    tests_run++;
    if (Stall_Cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_stall: got %0d want 0", Stall_Cnt); end
    tests_run++;
    if ({Out_Opcode, Out_Carry, Out_Zero, Out_Wide} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_flags: got op=%0d c=%b z=%b w=%b want all 0", Out_Opcode, Out_Carry, Out_Zero, Out_Wide);
    end
  endtask

  task automatic test_flags();
    Out_Ready = 1'b0;
    push_one(16'h00FF, 1'b1, 5'd0);
    tests_run++;
    if (Out_Valid !== 1'b1) begin tests_failed++; $display("FAIL flags_latency_valid: got %b want 1", Out_Valid); end
    push_one(16'h3840, 1'b1, 5'd2);
    tests_run++;
    if (Count !== 3'd2) begin tests_failed++; $display("FAIL flags_count: got %0d want 2", Count); end
    tests_run++;
    if (Out_Data !== 16'h00FF) begin tests_failed++; $display("FAIL flags_head0_data: got %h want 00ff", Out_Data); end
    tests_run++;
    if ({Out_Carry, Out_Zero, Out_Wide} !== 3'b100) begin
      tests_failed++;
      $display("FAIL flags_head0_flags: got c=%b z=%b w=%b want c=1 z=0 w=0", Out_Carry, Out_Zero, Out_Wide);
    end
    // Pop the first entry.
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    $display("[TB] pop  count=%0d head=%h", Count, Out_Data);
    tests_run++;
    if (Out_Data !== 16'h3840) begin tests_failed++; $display("FAIL flags_head1_data: got %h want 3840", Out_Data); end
    tests_run++;
    if ({Out_Carry, Out_Zero, Out_Wide} !== 3'b001) begin
      tests_failed++;
      $display("FAIL flags_head1_flags: got c=%b z=%b w=%b want c=0 z=0 w=1", Out_Carry, Out_Zero, Out_Wide);
    end
    tests_run++;
    if (Out_Opcode !== 5'd2) begin tests_failed++; $display("FAIL flags_head1_op: got %0d want 2", Out_Opcode); end
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    $display("[TB] pop  count=%0d head=%h", Count, Out_Data);
    tests_run++;
    if ({Out_Valid, Out_Data} !== 17'h0) begin
      tests_failed++;
      $display("FAIL flags_empty_mask: got valid=%b data=%h want 0/0000", Out_Valid, Out_Data);
    end
  endtask

  task automatic test_full_stall();
    logic [15:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      push_one(16'h1000 + 16'(i), 1'b0, 5'(i + 1));
    end
    tests_run++;
    if ({Count, In_Ready} !== {3'd4, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_state: got count=%0d in_ready=%b want 4/0", Count, In_Ready);
    end
    In_Valid = 1'b1;
    ALU_Out  = 16'hDEAD;
    Opcode   = 5'd9;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) begin
        tests_run++;
        if (Stall_Cnt !== 8'd1) begin tests_failed++; $display("FAIL stall_first: got %0d want 1", Stall_Cnt); end
      end
    end
    $display("[TB] stall 300 cycles stall_cnt=%0d", Stall_Cnt);
    tests_run++;
    if (Stall_Cnt !== 8'd255) begin tests_failed++; $display("FAIL stall_saturate: got %0d want 255", Stall_Cnt); end
    // Pop while full with input still valid: no pass-through push.
    Out_Ready = 1'b1;
    tick();
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    $display("[TB] pop  at full count=%0d head=%h", Count, Out_Data);
    tests_run++;
    if (Count !== 3'd3) begin tests_failed++; $display("FAIL full_no_passthru: got count=%0d want 3", Count); end
    tests_run++;
    if (Stall_Cnt !== 8'd255) begin tests_failed++; $display("FAIL stall_hold: got %0d want 255", Stall_Cnt); end
    for (int i = 1; i < 4; i++) begin
      exp_d = 16'h1000 + 16'(i);
      tests_run++;
      if (Out_Data !== exp_d || Out_Opcode !== 5'(i + 1)) begin
        tests_failed++;
        $display("FAIL full_order_%0d: got data=%h op=%0d want data=%h op=%0d", i, Out_Data, Out_Opcode, exp_d, i + 1);
      end
      Out_Ready = 1'b1;
      tick();
      Out_Ready = 1'b0;
      $display("[TB] pop  count=%0d", Count);
    end
    tests_run++;
    if (Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL full_drained: got valid=%b want 0", Out_Valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    push_one(16'hA000, 1'b0, 5'd3);
    push_one(16'hA001, 1'b0, 5'd3);
    In_Valid  = 1'b1;
    Out_Ready = 1'b1;
    Opcode    = 5'd3;
    for (int k = 0; k < 10; k++) begin
      ALU_Out = 16'hA002 + 16'(k);
      exp_d   = 16'hA000 + 16'(k);
      tests_run++;
      if (Out_Data !== exp_d) begin
        tests_failed++;
        $display("FAIL b2b_head_%0d: got %h want %h", k, Out_Data, exp_d);
      end
      tick();
      $display("[TB] push+pop data=%h count=%0d", ALU_Out, Count);
      tests_run++;
      if (Count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count_%0d: got %0d want 2", k, Count); end
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    tests_run++;
    if (Out_Data !== 16'hA00A) begin tests_failed++; $display("FAIL b2b_final_head: got %h want a00a", Out_Data); end
  endtask

  task automatic test_flush();
    push_one(16'hB000, 1'b0, 5'd4);
    tests_run++;
    if (Count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count: got %0d want 3", Count); end
    Flush     = 1'b1;
    In_Valid  = 1'b1;
    Out_Ready = 1'b1;
    ALU_Out   = 16'hB001;
    tick();
    idle_inputs();
    $display("[TB] flush count=%0d valid=%b stall=%0d", Count, Out_Valid, Stall_Cnt);
    tests_run++;
    if ({Count, Out_Valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL flush_empty: got count=%0d valid=%b want 0/0", Count, Out_Valid);
    end
    tests_run++;
    if (Stall_Cnt !== 8'd0) begin tests_failed++; $display("FAIL flush_stall: got %0d want 0", Stall_Cnt); end
    tests_run++;
    if (Out_Data !== 16'h0) begin tests_failed++; $display("FAIL flush_data_mask: got %h want 0000", Out_Data); end
  endtask

  task automatic test_zero_and_reset();
    push_one(16'h0000, 1'b1, 5'b11111);
    tests_run++;
    if ({Out_Zero, Out_Carry, Out_Wide} !== 3'b100) begin
      tests_failed++;
      $display("FAIL zero_flags: got z=%b c=%b w=%b want z=1 c=0 w=0", Out_Zero, Out_Carry, Out_Wide);
    end
    tests_run++;
    if (Out_Opcode !== 5'b11111) begin tests_failed++; $display("FAIL zero_op: got %0d want 31", Out_Opcode); end
    push_one(16'h0100, 1'b0, 5'd0);
    tests_run++;
    if (Count !== 3'd2) begin tests_failed++; $display("FAIL rst_pre_count: got %0d want 2", Count); end
    rst       = 1'b1;
    In_Valid  = 1'b1;
    Out_Ready = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    $display("[TB] reset count=%0d valid=%b", Count, Out_Valid);
    tests_run++;
    if ({Count, Out_Valid, In_Ready} !== {3'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_mid_stream: got count=%0d valid=%b in_ready=%b want 0/0/1", Count, Out_Valid, In_Ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_flags();
    test_full_stall();
    test_back_to_back();
    test_flush();
    test_zero_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
